// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, selects the next PC from the control unit,
// runs a req/ack handshake with a multi-cycle instruction memory and drives the
// IF/ID register. While a fetch is outstanding, a redirect is parked in a drain
// state so that the request and address stay stable until the memory acks.
module if_fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [2:0]  cu_pc_src,
   input  logic [31:0] cu_vector,
   input  logic        cu_pc_stall,
   input  logic        cu_ifid_stall,
   input  logic        cu_ifid_flush,
   input  logic [31:0] id_jmp_target,
   input  logic [31:0] mem_branch_target,
   input  logic [31:0] cp0_epc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] pc,
   output logic [31:0] ifid_pc,
   output logic [31:0] ifid_inst,
   output logic        ifid_valid,
   output logic        ifid_adel,
   output logic        if_fetch_stall
);

   typedef enum logic [1:0] {
      ST_REQ   = 2'd0,
      ST_DRAIN = 2'd1,
      ST_HOLD  = 2'd2
   } state_t;

   localparam logic [2:0] SRC_JMP = 3'd0;
   localparam logic [2:0] SRC_EXC = 3'd1;
   localparam logic [2:0] SRC_ERT = 3'd2;
   localparam logic [2:0] SRC_BR  = 3'd3;
   localparam logic [2:0] SRC_SEQ = 3'd4;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] redirect_pc_q, redirect_pc_d;
   logic [31:0] hold_inst_q, hold_inst_d;
   logic [31:0] ifid_pc_q, ifid_pc_d;
   logic [31:0] ifid_inst_q, ifid_inst_d;
   logic        ifid_valid_q, ifid_valid_d;
   logic        ifid_adel_q, ifid_adel_d;

   logic        redirect_s;
   logic        stall_s;
   logic        aligned_s;
   logic [31:0] target_s;
   logic        load_s;
   logic [31:0] load_inst_s;
   logic        load_valid_s;
   logic        load_adel_s;

   assign redirect_s = (cu_pc_src != SRC_SEQ);
   assign stall_s    = cu_pc_stall | cu_ifid_stall;
   assign aligned_s  = (pc_q[1:0] == 2'b00);

   // Redirect target selection from the control unit's PC source
   always_comb begin
      target_s = pc_q + 32'd4;
      case (cu_pc_src)
         SRC_JMP: target_s = id_jmp_target;
         SRC_EXC: target_s = cu_vector;
         SRC_ERT: target_s = cp0_epc;
         SRC_BR:  target_s = mem_branch_target;
         default: target_s = pc_q + 32'd4;
      endcase
   end

   // Memory request: aligned PC in REQ, always while draining, never during reset
   always_comb begin
      imem_req = 1'b0;
      if (reset) begin
         imem_req = 1'b0;
      end else begin
         case (state_q)
            ST_REQ:   imem_req = aligned_s;
            ST_DRAIN: imem_req = 1'b1;
            default:  imem_req = 1'b0;
         endcase
      end
   end

   assign imem_addr      = pc_q;
   assign if_fetch_stall = ((state_q == ST_REQ) & imem_req & ~imem_ack) | (state_q == ST_DRAIN);

   // Next-state for PC, fetch FSM and the candidate IF/ID entry produced this cycle
   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      redirect_pc_d = redirect_pc_q;
      hold_inst_d   = hold_inst_q;
      load_s        = 1'b0;
      load_inst_s   = NOP_INST;
      load_valid_s  = 1'b0;
      load_adel_s   = 1'b0;
      case (state_q)
         ST_REQ: begin
            if (!aligned_s) begin
               // No request goes out; report the address error into IF/ID instead
               if (redirect_s) begin
                  pc_d = target_s;
               end else if (!stall_s) begin
                  load_s      = 1'b1;
                  load_adel_s = 1'b1;
               end else begin
                  pc_d = pc_q;
               end
            end else if (imem_ack) begin
               if (redirect_s) begin
                  pc_d = target_s;
                  // A jump in ID keeps the word fetched alongside it: the delay slot
                  if ((cu_pc_src == SRC_JMP) && !stall_s) begin
                     load_s       = 1'b1;
                     load_inst_s  = imem_rdata;
                     load_valid_s = 1'b1;
                  end else begin
                     load_s = 1'b0;
                  end
               end else if (stall_s) begin
                  hold_inst_d = imem_rdata;
                  state_d     = ST_HOLD;
               end else begin
                  load_s       = 1'b1;
                  load_inst_s  = imem_rdata;
                  load_valid_s = 1'b1;
                  pc_d         = pc_q + 32'd4;
               end
            end else if (redirect_s) begin
               redirect_pc_d = target_s;
               state_d       = ST_DRAIN;
            end else begin
               state_d = ST_REQ;
            end
         end
         ST_DRAIN: begin
            if (imem_ack) begin
               pc_d    = redirect_s ? target_s : redirect_pc_q;
               state_d = ST_REQ;
            end else if (redirect_s) begin
               redirect_pc_d = target_s;
            end else begin
               state_d = ST_DRAIN;
            end
         end
         ST_HOLD: begin
            if (redirect_s) begin
               pc_d    = target_s;
               state_d = ST_REQ;
            end else if (!stall_s) begin
               load_s       = 1'b1;
               load_inst_s  = hold_inst_q;
               load_valid_s = 1'b1;
               pc_d         = pc_q + 32'd4;
               state_d      = ST_REQ;
            end else begin
               state_d = ST_HOLD;
            end
         end
         default: begin
            state_d = ST_REQ;
         end
      endcase
   end

   // IF/ID next value: flush beats stall, stall beats load, otherwise a bubble
   always_comb begin
      ifid_pc_d    = 32'd0;
      ifid_inst_d  = NOP_INST;
      ifid_valid_d = 1'b0;
      ifid_adel_d  = 1'b0;
      if (cu_ifid_flush) begin
         ifid_pc_d    = 32'd0;
         ifid_inst_d  = NOP_INST;
         ifid_valid_d = 1'b0;
         ifid_adel_d  = 1'b0;
      end else if (cu_ifid_stall) begin
         ifid_pc_d    = ifid_pc_q;
         ifid_inst_d  = ifid_inst_q;
         ifid_valid_d = ifid_valid_q;
         ifid_adel_d  = ifid_adel_q;
      end else if (load_s) begin
         ifid_pc_d    = pc_q;
         ifid_inst_d  = load_inst_s;
         ifid_valid_d = load_valid_s;
         ifid_adel_d  = load_adel_s;
      end else begin
         ifid_pc_d    = 32'd0;
         ifid_inst_d  = NOP_INST;
         ifid_valid_d = 1'b0;
         ifid_adel_d  = 1'b0;
      end
   end

   // State registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= ST_REQ;
         pc_q          <= RESET_PC;
         redirect_pc_q <= 32'd0;
         hold_inst_q   <= 32'd0;
         ifid_pc_q     <= 32'd0;
         ifid_inst_q   <= NOP_INST;
         ifid_valid_q  <= 1'b0;
         ifid_adel_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         redirect_pc_q <= redirect_pc_d;
         hold_inst_q   <= hold_inst_d;
         ifid_pc_q     <= ifid_pc_d;
         ifid_inst_q   <= ifid_inst_d;
         ifid_valid_q  <= ifid_valid_d;
         ifid_adel_q   <= ifid_adel_d;
      end
   end

   assign pc         = pc_q;
   assign ifid_pc    = ifid_pc_q;
   assign ifid_inst  = ifid_inst_q;
   assign ifid_valid = ifid_valid_q;
   assign ifid_adel  = ifid_adel_q;

endmodule
